// File: rtl/cla_nibble_serial_adder.sv
// Multi-nibble adder that walks WIDTH-bit operands through one 4-bit lookahead slice per cycle.
// Optional SUBTRACT_EN macro adds a sub port (A - B via ~B and forced carry-in).
module cla_nibble_serial_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cIn,
`ifdef SUBTRACT_EN
    input  logic             sub,
`endif
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] sum,
    output logic             cOut
);

    localparam int unsigned N  = WIDTH / 4;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;

    logic [WIDTH-1:0] b_load;
    logic             c_load;
    logic [3:0]       g, p, k, nib_sum;
    logic [WIDTH+3:0] sum_ext;

`ifdef SUBTRACT_EN
    assign b_load = sub ? ~B : B;
    assign c_load = sub ? 1'b1 : cIn;
`else
    assign b_load = B;
    assign c_load = cIn;
`endif

    // 4-bit lookahead slice on the low nibble of the operand shift registers
    always_comb begin
        g       = a_q[3:0] & b_q[3:0];
        p       = a_q[3:0] ^ b_q[3:0];
        k[0]    = g[0] | (p[0] & c_q);
        k[1]    = g[1] | (p[1] & k[0]);
        k[2]    = g[2] | (p[2] & k[1]);
        k[3]    = g[3] | (p[3] & k[2]);
        nib_sum = p ^ {k[2:0], c_q};
        sum_ext = {nib_sum, sum_q};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        cout_d  = cout_q;
        unique case (state_q)
            StIdle: begin
                if (inValid) begin
                    a_d     = A;
                    b_d     = b_load;
                    c_d     = c_load;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                // Sum fills from the MSB end so nibble 0 lands at the bottom after N shifts
                sum_d = sum_ext[WIDTH+3:4];
                a_d   = a_q >> 4;
                b_d   = b_q >> 4;
                c_d   = k[3];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    cout_d  = k[3];
                    state_d = StDone;
                end
            end
            StDone: begin
                if (outReady) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
        end
    end

    assign inReady  = (state_q == StIdle);
    assign outValid = (state_q == StDone);
    assign sum      = sum_q;
    assign cOut     = cout_q;

endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// Directed bench for cla_nibble_serial_adder: vector table plus backpressure, reset-abort,
// WIDTH=4 and (with SUBTRACT_EN) subtract sequences.
module tb_cla_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        c_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] sum;
    logic        c_out;
`ifdef SUBTRACT_EN
    logic        sub_r = 1'b0;
    logic        w4_sub = 1'b0;
`endif

    logic       w4_in_valid = 1'b0;
    logic       w4_in_ready;
    logic [3:0] w4_a = '0;
    logic [3:0] w4_b = '0;
    logic       w4_c_in = 1'b0;
    logic       w4_out_valid;
    logic       w4_out_ready = 1'b0;
    logic [3:0] w4_sum;
    logic       w4_c_out;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    cla_nibble_serial_adder #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .inValid(in_valid), .inReady(in_ready),
        .A(a), .B(b), .cIn(c_in),
`ifdef SUBTRACT_EN
        .sub(sub_r),
`endif
        .outValid(out_valid), .outReady(out_ready), .sum(sum), .cOut(c_out)
    );

    cla_nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .inValid(w4_in_valid), .inReady(w4_in_ready),
        .A(w4_a), .B(w4_b), .cIn(w4_c_in),
`ifdef SUBTRACT_EN
        .sub(w4_sub),
`endif
        .outValid(w4_out_valid), .outReady(w4_out_ready), .sum(w4_sum), .cOut(w4_c_out)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] s;
        logic        co;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, exp);
        end
    endtask

    // Waits (bounded) for out_valid; returns edge count including the acceptance edge
    task automatic wait_valid(output int edges);
        edges = 1;
        while (!out_valid && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic run_op(input string name, input logic [15:0] av, input logic [15:0] bv,
                          input logic cv, input logic [15:0] es, input logic ec);
        int edges;
        @(negedge clk);
        a = av; b = bv; c_in = cv; in_valid = 1'b1;
        check({name, ".in_ready"}, in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_valid(edges);
        check({name, ".latency"}, edges, 5);
        check({name, ".sum"}, sum, es);
        check({name, ".cout"}, c_out, ec);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check({name, ".consumed_valid"}, out_valid, 0);
        check({name, ".consumed_ready"}, in_ready, 1);
    endtask

    initial begin
        int edges;
        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
        vecs[3] = '{16'h00FF, 16'h0F0F, 1'b0, 16'h100E, 1'b0};
        vecs[4] = '{16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0};
        vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[7] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};

        #12;
        check("rst.in_ready", in_ready, 1);
        check("rst.out_valid", out_valid, 0);
        check("rst.sum", sum, 0);
        check("rst.cout", c_out, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                                          vecs[i].cin, vecs[i].s, vecs[i].co);

        // Backpressure, with a new request held on inValid throughout
        @(negedge clk);
        a = 16'h00FF; b = 16'h0F0F; c_in = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 a = 16'h1111; b = 16'h2222;
        wait_valid(edges);
        check("bp.latency", edges, 5);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp.hold%0d.valid", i), out_valid, 1);
            check($sformatf("bp.hold%0d.sum", i), sum, 16'h100E);
            check($sformatf("bp.hold%0d.cout", i), c_out, 0);
            check($sformatf("bp.hold%0d.in_ready", i), in_ready, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("bp.consumed_ready", in_ready, 1);
        check("bp.consumed_valid", out_valid, 0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("bp.new_accepted", in_ready, 0);
        wait_valid(edges);
        check("bp.new.latency", edges, 5);
        check("bp.new.sum", sum, 16'h3333);
        check("bp.new.cout", c_out, 0);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;

        // Reset asserted during the 2nd RUN cycle
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; c_in = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort.out_valid", out_valid, 0);
        check("abort.sum", sum, 0);
        check("abort.in_ready", in_ready, 1);
        check("abort.cout", c_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after_abort", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);

        // WIDTH=4 instance: one RUN cycle
        @(negedge clk);
        w4_a = 4'h9; w4_b = 4'h8; w4_c_in = 1'b1; w4_in_valid = 1'b1;
        @(posedge clk);
        #1 w4_in_valid = 1'b0;
        check("w4.run_valid", w4_out_valid, 0);
        @(posedge clk);
        #1;
        check("w4.valid", w4_out_valid, 1);
        check("w4.sum", w4_sum, 4'h2);
        check("w4.cout", w4_c_out, 1);
        @(negedge clk);
        w4_out_ready = 1'b1;
        @(posedge clk);
        #1 w4_out_ready = 1'b0;
        check("w4.consumed_ready", w4_in_ready, 1);

`ifdef SUBTRACT_EN
        sub_r = 1'b1;
        run_op("sub5m7", 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0);
        run_op("sub7m5", 16'h0007, 16'h0005, 1'b0, 16'h0002, 1'b1);
        sub_r = 1'b0;
        run_op("sub_off", 16'h0007, 16'h0005, 1'b0, 16'h000C, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
